// File: rtl/pll_rst_ctrl.sv
// PLL reset supervisor: holds the PLL in reset, waits for a synchronised lock with timeout and
// retry, qualifies lock stability, then releases a registered reset to downstream logic.
module pll_rst_ctrl #(
  parameter int unsigned RST_HOLD_CYC     = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned MAX_RETRY        = 7,
  localparam int unsigned RW              = $clog2(MAX_RETRY + 1)
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          pll_lock,
  input  logic          relock_req,
  output logic          pll_rst,
  output logic          rst_n_out,
  output logic          locked,
  output logic          fail,
  output logic [RW-1:0] retry_cnt,
  output logic [2:0]    state
);

  localparam int unsigned MAX_A   = (LOCK_TIMEOUT_CYC > LOCK_STABLE_CYC) ? LOCK_TIMEOUT_CYC
                                                                         : LOCK_STABLE_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > RST_HOLD_CYC) ? MAX_A : RST_HOLD_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRY - 1);
  localparam logic [RW-1:0] RETRY_FULL   = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_HOLD = 3'd0,
    S_WAIT = 3'd1,
    S_STAB = 3'd2,
    S_RUN  = 3'd3,
    S_FAIL = 3'd4
  } state_t;

  state_t          st;
  logic [CW-1:0]   cnt;
  logic            lock_meta;
  logic            lock_s;

  // pll_lock comes from the PLL's own lock detector and is asynchronous to sys_clk.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old values, forming a real
      // two-stage chain; blocking here would collapse it into a single flop.
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // Every output is assigned on the same edge as the state transition that implies it,
  // so the outputs are registered and always consistent with state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st        <= S_HOLD;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      rst_n_out <= 1'b0;
      locked    <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
    end else begin
      case (st)
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            st      <= S_WAIT;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_WAIT: begin
          if (lock_s) begin
            st  <= S_STAB;
            cnt <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt     <= '0;
            pll_rst <= 1'b1;
            if (retry_cnt == RETRY_LAST) begin
              st        <= S_FAIL;
              retry_cnt <= RETRY_FULL;
              fail      <= 1'b1;
            end else begin
              st        <= S_HOLD;
              retry_cnt <= retry_cnt + RW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_STAB: begin
          // A lock drop here restarts the timeout window but is not a failed attempt.
          if (!lock_s) begin
            st  <= S_WAIT;
            cnt <= '0;
          end else if (cnt == STABLE_LAST) begin
            st        <= S_RUN;
            cnt       <= '0;
            rst_n_out <= 1'b1;
            locked    <= 1'b1;
            retry_cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_RUN: begin
          if (!lock_s || relock_req) begin
            st        <= S_HOLD;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            rst_n_out <= 1'b0;
            locked    <= 1'b0;
            retry_cnt <= '0;
          end
        end

        S_FAIL: begin
          if (relock_req) begin
            st        <= S_HOLD;
            cnt       <= '0;
            fail      <= 1'b0;
            retry_cnt <= '0;
          end
        end

        default: begin
          st        <= S_HOLD;
          cnt       <= '0;
          pll_rst   <= 1'b1;
          rst_n_out <= 1'b0;
          locked    <= 1'b0;
          fail      <= 1'b0;
          retry_cnt <= '0;
        end
      endcase
    end
  end

  assign state = st;

endmodule
